// File: rtl/rns_crt_reconstruct_if.sv
`default_nettype none
// ============================================================================
// Module   : rns_crt_reconstruct_if
// Brief    : Operand/result handshake bundle for the RNS-to-binary converter.
// Revision : 1.0
// ============================================================================
interface rns_crt_reconstruct_if #(
  parameter int SWIDTH = 16
);
  logic                  in_valid;
  logic                  in_ready;
  logic [SWIDTH-1:0]     q0;
  logic [SWIDTH-1:0]     q1;
  logic [SWIDTH-1:0]     q0_inv;
  logic [SWIDTH:0]       mu;
  logic [SWIDTH-1:0]     r0;
  logic [SWIDTH-1:0]     r1;
  logic                  out_valid;
  logic                  out_ready;
  logic [2*SWIDTH-1:0]   x;
  logic                  out_err;

  modport master (
    output in_valid, q0, q1, q0_inv, mu, r0, r1, out_ready,
    input  in_ready, out_valid, x, out_err
  );

  modport slave (
    input  in_valid, q0, q1, q0_inv, mu, r0, r1, out_ready,
    output in_ready, out_valid, x, out_err
  );
endinterface
`default_nettype wire

// File: rtl/rns_crt_reconstruct.sv
`default_nettype none
// ============================================================================
// Module   : rns_crt_reconstruct
// Brief    : Two-modulus Garner CRT reconstruction, multi-cycle FSM with an
//            internal Barrett reducer. Optional CRT_RANGE_CHECK_EN adds input
//            range checking with an out_err flag.
// Revision : 1.0
// ============================================================================
module rns_crt_reconstruct #(
  parameter int SWIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  rns_crt_reconstruct_if.slave  bus
);
  localparam int K = SWIDTH;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_DIFF = 3'd1;
  localparam logic [2:0] S_MUL  = 3'd2;
  localparam logic [2:0] S_RED  = 3'd3;
  localparam logic [2:0] S_CORR = 3'd4;
  localparam logic [2:0] S_ACC  = 3'd5;
  localparam logic [2:0] S_DONE = 3'd6;

  logic [2:0]     state_q, state_d;
  logic [K-1:0]   q0_q, q0_d, q1_q, q1_d, qinv_q, qinv_d;
  logic [K-1:0]   r0_q, r0_d, r1_q, r1_d;
  logic [K:0]     mu_q, mu_d;
  logic [K-1:0]   d_q, d_d, h_q, h_d;
  logic [2*K-1:0] p_q, p_d, x_q, x_d;
  logic [K+1:0]   t_q, t_d;

  logic           w_accept;
  logic           w_range_bad;
  logic           w_err_now;
  logic [K:0]     w_e;
  logic [K+1:0]   w_q1_ext;
  logic [K+1:0]   w_t1;

  assign w_accept = bus.in_valid && (state_q == S_IDLE);

  // Barrett quotient estimate from the full 3k+1-bit product p*mu
  assign w_e = (K+1)'(({{(K+1){1'b0}}, p_q} * {{(2*K){1'b0}}, mu_q}) >> (2*K));

  assign w_q1_ext = {2'b00, q1_q};
  assign w_t1     = (t_q >= w_q1_ext) ? t_q - w_q1_ext : t_q;

  always_comb begin
    state_d = state_q;
    q0_d    = q0_q;
    q1_d    = q1_q;
    qinv_d  = qinv_q;
    mu_d    = mu_q;
    r0_d    = r0_q;
    r1_d    = r1_q;
    d_d     = d_q;
    p_d     = p_q;
    t_d     = t_q;
    h_d     = h_q;
    x_d     = x_q;
    case (state_q)
      S_IDLE: begin
        if (w_accept) begin
          q0_d    = bus.q0;
          q1_d    = bus.q1;
          qinv_d  = bus.q0_inv;
          mu_d    = bus.mu;
          r0_d    = bus.r0;
          r1_d    = bus.r1;
          state_d = S_DIFF;
        end
      end
      S_DIFF: begin
        // The wrapped k-bit sum is exact because the true result is < q1
        d_d     = (r1_q >= r0_q) ? r1_q - r0_q : r1_q + q1_q - r0_q;
        state_d = w_range_bad ? S_ACC : S_MUL;
      end
      S_MUL: begin
        p_d     = {{K{1'b0}}, d_q} * {{K{1'b0}}, qinv_q};
        state_d = S_RED;
      end
      S_RED: begin
        t_d     = (K+2)'({1'b0, p_q} - ({{K{1'b0}}, w_e} * {{(K+1){1'b0}}, q1_q}));
        state_d = S_CORR;
      end
      S_CORR: begin
        h_d     = K'((w_t1 >= w_q1_ext) ? w_t1 - w_q1_ext : w_t1);
        state_d = S_ACC;
      end
      S_ACC: begin
        // Range-violation path also passes through here to zero the result
        x_d     = w_err_now ? '0
                            : {{K{1'b0}}, r0_q} + {{K{1'b0}}, q0_q} * {{K{1'b0}}, h_q};
        state_d = S_DONE;
      end
      S_DONE: begin
        if (bus.out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      q0_q    <= '0;
      q1_q    <= '0;
      qinv_q  <= '0;
      mu_q    <= '0;
      r0_q    <= '0;
      r1_q    <= '0;
      d_q     <= '0;
      p_q     <= '0;
      t_q     <= '0;
      h_q     <= '0;
      x_q     <= '0;
    end else begin
      state_q <= state_d;
      q0_q    <= q0_d;
      q1_q    <= q1_d;
      qinv_q  <= qinv_d;
      mu_q    <= mu_d;
      r0_q    <= r0_d;
      r1_q    <= r1_d;
      d_q     <= d_d;
      p_q     <= p_d;
      t_q     <= t_d;
      h_q     <= h_d;
      x_q     <= x_d;
    end
  end

`ifdef CRT_RANGE_CHECK_EN
  logic err_q, err_d;

  assign w_range_bad = (r0_q >= q0_q) || (r1_q >= q1_q) ||
                       (q0_q >= q1_q) || (qinv_q >= q1_q);

  always_comb begin
    err_d = err_q;
    if (w_accept)
      err_d = 1'b0;
    else if ((state_q == S_DIFF) && w_range_bad)
      err_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= 1'b0;
    else        err_q <= err_d;
  end

  assign w_err_now   = err_q;
  assign bus.out_err = err_q;
`else
  assign w_range_bad = 1'b0;
  assign w_err_now   = 1'b0;
  assign bus.out_err = 1'b0;
`endif

  assign bus.in_ready  = (state_q == S_IDLE);
  assign bus.out_valid = (state_q == S_DONE);
  assign bus.x         = x_q;

endmodule
`default_nettype wire

// File: tb/tb_rns_crt_reconstruct.sv
`default_nettype none
// ============================================================================
// Module   : tb_rns_crt_reconstruct
// Brief    : Directed checks of rns_crt_reconstruct with q0=13, q1=15.
// Revision : 1.0
// ============================================================================
module tb_rns_crt_reconstruct;
  localparam int SW = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;

  rns_crt_reconstruct_if #(.SWIDTH(SW)) bus ();

  rns_crt_reconstruct #(.SWIDTH(SW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Present an operand set, wait for its accept edge, then scramble inputs.
  task automatic drive_op(input logic [3:0] a, input logic [3:0] b, output int n);
    logic acc;
    acc = 1'b0;
    n   = 0;
    bus.q0 = 4'd13; bus.q1 = 4'd15; bus.q0_inv = 4'd7; bus.mu = 5'd17;
    bus.r0 = a;     bus.r1 = b;     bus.in_valid = 1'b1;
    for (int i = 0; i < 40; i++) begin
      acc = bus.in_ready;
      @(posedge clk); #1;
      n = i + 1;
      if (acc) break;
    end
    if (!acc) begin
      n_cmp++; n_bad++;
      $display("FAIL accept_timeout: in_ready never seen, got 0 expected 1");
    end
    bus.in_valid = 1'b0;
    bus.q0 = 4'd3; bus.q1 = 4'd2; bus.q0_inv = 4'd1; bus.mu = 5'd0;
    bus.r0 = 4'd5; bus.r1 = 4'd9;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!bus.out_valid && n < 30) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic test_reset();
    #3 rst_n = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready: got %0b expected 1", bus.in_ready); end
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %0b expected 0", bus.out_valid); end
    n_cmp++; if (bus.x !== 8'd0) begin n_bad++; $display("FAIL reset_x: got %0d expected 0", bus.x); end
    n_cmp++; if (bus.out_err !== 1'b0) begin n_bad++; $display("FAIL reset_out_err: got %0b expected 0", bus.out_err); end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_nominal();
    int n;
    bus.out_ready = 1'b1;
    drive_op(4'd9, 4'd10, n);
    wait_valid(n);
    n_cmp++; if (n != 5) begin n_bad++; $display("FAIL nominal_latency: got %0d expected 5", n); end
    n_cmp++; if (bus.x !== 8'd100) begin n_bad++; $display("FAIL nominal_x: got %0d expected 100", bus.x); end
    n_cmp++; if (bus.out_err !== 1'b0) begin n_bad++; $display("FAIL nominal_err: got %0b expected 0", bus.out_err); end
    n_cmp++; if (bus.in_ready !== 1'b0) begin n_bad++; $display("FAIL nominal_in_ready_busy: got %0b expected 0", bus.in_ready); end
    @(posedge clk); #1;
    n_cmp++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      n_bad++; $display("FAIL nominal_return_idle: got in_ready=%0b out_valid=%0b expected 1/0", bus.in_ready, bus.out_valid);
    end
  endtask

  task automatic test_borrow();
    int n;
    bus.out_ready = 1'b1;
    drive_op(4'd12, 4'd10, n);
    wait_valid(n);
    n_cmp++; if (n != 5) begin n_bad++; $display("FAIL borrow_latency: got %0d expected 5", n); end
    n_cmp++; if (bus.x !== 8'd25) begin n_bad++; $display("FAIL borrow_x: got %0d expected 25", bus.x); end
    @(posedge clk); #1;
  endtask

  task automatic test_extremes();
    int n;
    bus.out_ready = 1'b1;
    drive_op(4'd0, 4'd0, n);
    wait_valid(n);
    n_cmp++; if (bus.x !== 8'd0) begin n_bad++; $display("FAIL extreme_zero_x: got %0d expected 0", bus.x); end
    @(posedge clk); #1;
    drive_op(4'd12, 4'd14, n);
    wait_valid(n);
    n_cmp++; if (bus.x !== 8'd194) begin n_bad++; $display("FAIL extreme_max_x: got %0d expected 194", bus.x); end
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    int n;
    int bad;
    bad = 0;
    bus.out_ready = 1'b0;
    drive_op(4'd9, 4'd10, n);
    wait_valid(n);
    for (int i = 0; i < 10; i++) begin
      n_cmp++;
      if (bus.out_valid !== 1'b1 || bus.x !== 8'd100 || bus.in_ready !== 1'b0) begin
        n_bad++;
        $display("FAIL backpressure_hold cycle %0d: got out_valid=%0b x=%0d in_ready=%0b expected 1/100/0",
                 i, bus.out_valid, bus.x, bus.in_ready);
      end
      @(posedge clk); #1;
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      n_bad++; $display("FAIL backpressure_release: got out_valid=%0b in_ready=%0b expected 0/1", bus.out_valid, bus.in_ready);
    end
  endtask

  task automatic test_reset_mid();
    int n;
    logic seen;
    seen = 1'b0;
    bus.out_ready = 1'b1;
    drive_op(4'd9, 4'd10, n);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL midreset_out_valid: got %0b expected 0", bus.out_valid); end
    n_cmp++; if (bus.x !== 8'd0) begin n_bad++; $display("FAIL midreset_x: got %0d expected 0", bus.x); end
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL midreset_in_ready: got %0b expected 1", bus.in_ready); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (bus.out_valid) seen = 1'b1;
      @(posedge clk); #1;
    end
    n_cmp++; if (seen !== 1'b0) begin n_bad++; $display("FAIL midreset_no_result: got out_valid seen=1 expected 0"); end
  endtask

  task automatic test_back_to_back();
    int n;
    bus.out_ready = 1'b1;
    drive_op(4'd12, 4'd10, n);
    drive_op(4'd0, 4'd0, n);
    n_cmp++; if (n != 7) begin n_bad++; $display("FAIL b2b_interval: got %0d expected 7", n); end
    wait_valid(n);
    n_cmp++; if (bus.x !== 8'd0) begin n_bad++; $display("FAIL b2b_second_x: got %0d expected 0", bus.x); end
    @(posedge clk); #1;
  endtask

`ifdef CRT_RANGE_CHECK_EN
  task automatic test_range_check();
    int n;
    bus.out_ready = 1'b1;
    drive_op(4'd13, 4'd10, n);
    wait_valid(n);
    n_cmp++; if (n != 2) begin n_bad++; $display("FAIL range_latency: got %0d expected 2", n); end
    n_cmp++; if (bus.out_err !== 1'b1) begin n_bad++; $display("FAIL range_err: got %0b expected 1", bus.out_err); end
    n_cmp++; if (bus.x !== 8'd0) begin n_bad++; $display("FAIL range_x: got %0d expected 0", bus.x); end
    @(posedge clk); #1;
    drive_op(4'd9, 4'd10, n);
    n_cmp++; if (bus.out_err !== 1'b0) begin n_bad++; $display("FAIL range_err_clear: got %0b expected 0", bus.out_err); end
    wait_valid(n);
    n_cmp++; if (bus.x !== 8'd100 || bus.out_err !== 1'b0) begin
      n_bad++; $display("FAIL range_recover: got x=%0d err=%0b expected 100/0", bus.x, bus.out_err);
    end
    @(posedge clk); #1;
  endtask
`endif

  task automatic test_sweep();
    int   n;
    logic got;
    logic hs;
    logic [7:0] xe;
    for (int xv = 0; xv < 195; xv++) begin
      xe  = 8'(xv);
      got = 1'b0;
      hs  = 1'b0;
      bus.out_ready = 1'($urandom_range(0, 1));
      drive_op(4'(xv % 13), 4'(xv % 15), n);
      for (int c = 0; c < 60; c++) begin
        if (bus.out_valid) begin
          if (!got) begin
            n_cmp++;
            if (bus.x !== xe) begin n_bad++; $display("FAIL sweep_x: got %0d expected %0d", bus.x, xe); end
          end
          got = 1'b1;
        end
        n_cmp++;
        if (bus.out_valid && bus.in_ready) begin
          n_bad++; $display("FAIL sweep_ready_overlap: got in_ready=1 with out_valid=1 expected in_ready=0");
        end
        bus.out_ready = 1'($urandom_range(0, 1));
        hs = bus.out_valid && bus.out_ready;
        @(posedge clk); #1;
        if (hs) break;
      end
      if (!hs) begin
        n_cmp++; n_bad++;
        $display("FAIL sweep_timeout: x=%0d got no handshake expected one", xe);
      end
    end
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.q0 = 4'd13; bus.q1 = 4'd15; bus.q0_inv = 4'd7; bus.mu = 5'd17;
    bus.r0 = 4'd0;  bus.r1 = 4'd0;
    test_reset();
    test_nominal();
    test_borrow();
    test_extremes();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
`ifdef CRT_RANGE_CHECK_EN
    test_range_check();
`endif
    test_sweep();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
